// File: rtl/extremum_pkg.sv
// Shared types for extremum_tracker: detection mode, slope FSM and refractory FSM encodings.
package extremum_pkg;

  typedef enum logic [1:0] {
    MODE_MAX  = 2'd0,
    MODE_MIN  = 2'd1,
    MODE_BOTH = 2'd2,
    MODE_OFF  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FLAT  = 2'd1,
    S_RISE  = 2'd2,
    S_FALL  = 2'd3
  } slope_state_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_ACTIVE = 1'b1
  } refr_state_t;

  function automatic logic mode_allows(input mode_t m, input logic is_max);
    return (m == MODE_BOTH) || (is_max ? (m == MODE_MAX) : (m == MODE_MIN));
  endfunction

endpackage

// File: rtl/refractory_timer.sv
// Refractory window: loads a length on start (from idle only), counts down on ce ticks.
module refractory_timer
  import extremum_pkg::*;
#(
  parameter int CTR_WIDTH = 22
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ce,
  input  logic                 i_start,
  input  logic [CTR_WIDTH-1:0] i_len,
  output logic                 o_active
);

  refr_state_t          state_q, state_d;
  logic [CTR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      R_IDLE: begin
        if (i_start && (i_len != '0)) begin
          state_d = R_ACTIVE;
          cnt_d   = i_len;
        end
      end
      R_ACTIVE: begin
        if (i_ce) begin
          if (cnt_q == CTR_WIDTH'(1)) begin
            state_d = R_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CTR_WIDTH'(1);
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb o_active = (state_q == R_ACTIVE);

endmodule

// File: rtl/extremum_tracker.sv
// Slope-based local max/min detector with window, threshold and refractory gating.
// Define EXTREMUM_TIMESTAMP_EN to capture i_ctr with each extremum; otherwise o_extremum_ctr is 0.
module extremum_tracker
  import extremum_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int CTR_WIDTH  = 22
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ce,
  input  logic [CTR_WIDTH-1:0]         i_ctr,
  input  logic [1:0]                   i_mode,
  input  logic signed [DATA_WIDTH-1:0] i_threshold,
  input  logic [CTR_WIDTH-1:0]         i_refractory_len,
  input  logic                         i_qrs_win_active,
  input  logic signed [DATA_WIDTH-1:0] i_signal,
  input  logic                         i_signal_valid,
  output logic                         o_extremum_found,
  output logic                         o_extremum_is_max,
  output logic signed [DATA_WIDTH-1:0] o_extremum_value,
  output logic [CTR_WIDTH-1:0]         o_extremum_ctr,
  output logic                         o_refractory_win_active
);

  slope_state_t                 slope_q, slope_d;
  logic signed [DATA_WIDTH-1:0] prev_q, value_q;
  logic                         found_q, is_max_q;
  logic signed [DATA_WIDTH:0]   sig_x, prev_x, thr_x, nthr_x;
  logic                         cand_max, cand_min, qual;
  logic                         refr_active;
  mode_t                        mode;

  assign mode   = mode_t'(i_mode);
  // One extra bit so negating the threshold and comparing extremes never wraps.
  assign sig_x  = {i_signal[DATA_WIDTH-1], i_signal};
  assign prev_x = {prev_q[DATA_WIDTH-1], prev_q};
  assign thr_x  = {i_threshold[DATA_WIDTH-1], i_threshold};
  assign nthr_x = -thr_x;

  always_ff @(posedge i_clk) begin
    if (i_rst) slope_q <= S_EMPTY;
    else       slope_q <= slope_d;
  end

  always_comb begin
    slope_d = slope_q;
    if (i_signal_valid) begin
      if (slope_q == S_EMPTY)   slope_d = S_FLAT;
      else if (sig_x > prev_x)  slope_d = S_RISE;
      else if (sig_x < prev_x)  slope_d = S_FALL;
    end
  end

  always_comb begin
    cand_max = i_signal_valid && (slope_q == S_RISE) && (sig_x < prev_x);
    cand_min = i_signal_valid && (slope_q == S_FALL) && (sig_x > prev_x);
    qual     = i_qrs_win_active && !refr_active &&
               ((cand_max && mode_allows(mode, 1'b1) && (prev_x >= thr_x)) ||
                (cand_min && mode_allows(mode, 1'b0) && (prev_x <= nthr_x)));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q   <= '0;
      found_q  <= 1'b0;
      is_max_q <= 1'b0;
      value_q  <= '0;
    end else begin
      if (i_signal_valid) prev_q <= i_signal;
      found_q <= qual;
      if (qual) begin
        is_max_q <= cand_max;
        value_q  <= prev_q;
      end
    end
  end

`ifdef EXTREMUM_TIMESTAMP_EN
  logic [CTR_WIDTH-1:0] prev_ctr_q, ctr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_ctr_q <= '0;
      ctr_q      <= '0;
    end else begin
      if (i_signal_valid) prev_ctr_q <= i_ctr;
      if (qual)           ctr_q      <= prev_ctr_q;
    end
  end

  assign o_extremum_ctr = ctr_q;
`else
  logic unused_ctr;
  assign unused_ctr     = ^i_ctr;
  assign o_extremum_ctr = '0;
`endif

  // Started by the registered pulse, so the window rises the cycle after it.
  refractory_timer #(.CTR_WIDTH(CTR_WIDTH)) u_refr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ce     (i_ce),
    .i_start  (found_q),
    .i_len    (i_refractory_len),
    .o_active (refr_active)
  );

  assign o_extremum_found        = found_q;
  assign o_extremum_is_max       = is_max_q;
  assign o_extremum_value        = value_q;
  assign o_refractory_win_active = refr_active;

endmodule

// File: tb/tb_extremum_tracker.sv
// Self-checking bench for extremum_tracker: directed scenarios plus random stimulus vs. a sample-level model.
module tb_extremum_tracker;
  localparam int DW = 11;
  localparam int CW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, ce, win, sv;
  logic [CW-1:0]        ctr, len;
  logic [1:0]           mode;
  logic signed [DW-1:0] thr, sig;
  logic                 found, is_max, refr;
  logic signed [DW-1:0] val;
  logic [CW-1:0]        xctr;

  extremum_tracker #(.DATA_WIDTH(DW), .CTR_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_ctr(ctr), .i_mode(mode),
    .i_threshold(thr), .i_refractory_len(len), .i_qrs_win_active(win),
    .i_signal(sig), .i_signal_valid(sv),
    .o_extremum_found(found), .o_extremum_is_max(is_max), .o_extremum_value(val),
    .o_extremum_ctr(xctr), .o_refractory_win_active(refr)
  );

  int nchk = 0, nerr = 0;
  int npulse, nrefr;
  int seq[$];

  // Reference model: last direction of change, previous sample, refractory ticks remaining.
  int     m_have, m_dir, m_prev, m_rem;
  longint m_pts;
  int     e_found, e_max, e_val;
  longint e_ctr;

  task automatic chk(input string tag, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int s, t;
    bit act, cmax, cmin, q;
    s = sig;
    t = thr;
    if (rst) begin
      m_have = 0; m_dir = 0; m_prev = 0; m_pts = 0; m_rem = 0;
      e_found = 0; e_max = 0; e_val = 0; e_ctr = 0;
    end else begin
      act  = (m_rem > 0);
      cmax = sv && (m_have != 0) && (m_dir == 1)  && (s < m_prev);
      cmin = sv && (m_have != 0) && (m_dir == -1) && (s > m_prev);
      q = win && !act &&
          ((cmax && (mode == 0 || mode == 2) && m_prev >= t) ||
           (cmin && (mode == 1 || mode == 2) && m_prev <= -t));
      if (m_rem > 0) begin
        if (ce) m_rem--;
      end else if (e_found != 0 && len != 0) begin
        m_rem = int'(len);
      end
      e_found = q;
      if (q) begin
        e_max = cmax;
        e_val = m_prev;
`ifdef EXTREMUM_TIMESTAMP_EN
        e_ctr = m_pts;
`else
        e_ctr = 0;
`endif
      end
      if (sv) begin
        if (m_have == 0) begin
          m_have = 1;
          m_dir  = 0;
        end else if (s > m_prev) m_dir = 1;
        else if (s < m_prev)     m_dir = -1;
        m_prev = s;
        m_pts  = ctr;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("found",  found,  e_found);
    chk("is_max", is_max, e_max);
    chk("value",  val,    e_val);
    chk("ctr",    xctr,   e_ctr);
    chk("refr",   refr,   (m_rem > 0) ? 1 : 0);
    if (found) npulse++;
    if (refr)  nrefr++;
    ctr = ctr + 1'b1;
  endtask

  task automatic clr();
    npulse = 0;
    nrefr  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sv  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    clr();
  endtask

  task automatic play(input bit gaps);
    foreach (seq[i]) begin
      if (gaps) begin
        repeat ($urandom_range(2, 0)) begin
          sv  = 1'b0;
          sig = DW'($urandom);
          cyc();
        end
      end
      sv  = 1'b1;
      sig = DW'(seq[i]);
      cyc();
    end
    sv = 1'b0;
    repeat (8) cyc();
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; win = 1'b1; sv = 1'b0;
    ctr = CW'(100); len = '0; mode = 2'd0; thr = '0; sig = '0;
    do_reset();

    // Peak 20 over threshold 10, refractory 3 ticks
    mode = 2'd0; thr = 11'sd10; len = CW'(3); ce = 1'b1; win = 1'b1;
    do_reset();
    seq = '{0, 5, 20, 15, 14, 13};
    play(1'b0);
    chk("s1_pulses", npulse, 1);
    chk("s1_is_max", is_max, 1);
    chk("s1_value",  val, 20);
    chk("s1_refr_cycles", nrefr, 3);

    // Plateaus, both polarities, no refractory
    mode = 2'd2; thr = '0; len = '0;
    do_reset();
    seq = '{0, 8, 8, 8, 2, -9, -9, 4};
    play(1'b0);
    chk("s2_pulses", npulse, 2);
    chk("s2_is_max", is_max, 0);
    chk("s2_value",  val, -9);
    chk("s2_refr_cycles", nrefr, 0);

    // Threshold and window suppression; slope keeps tracking
    mode = 2'd0; thr = 11'sd30; len = '0;
    do_reset();
    seq = '{0, 20, 10};
    play(1'b0);
    chk("s3_thr_pulses", npulse, 0);
    thr = '0; win = 1'b0; clr();
    seq = '{30, 20};
    play(1'b0);
    chk("s3_win_pulses", npulse, 0);
    win = 1'b1; clr();
    seq = '{40, 35};
    play(1'b0);
    chk("s3_pulses", npulse, 1);
    chk("s3_value",  val, 40);

    // Refractory 5: second peak suppressed, one at expiry suppressed, later one reported
    mode = 2'd0; thr = '0; len = CW'(5);
    do_reset();
    seq = '{0, 10, 0, 10, 0, 10, 0, 10, 0, 10, 0};
    play(1'b0);
    chk("s4_pulses", npulse, 2);
    chk("s4_refr_cycles", nrefr, 10);

    // Gaps in the valid stream and full-scale swings
    mode = 2'd2; thr = '0; len = '0;
    do_reset();
    seq = '{0, 8, 8, 8, 2, -9, -9, 4};
    play(1'b1);
    chk("s5_gap_pulses", npulse, 2);
    chk("s5_gap_value",  val, -9);
    do_reset();
    seq = '{-1024, 1023, -1024};
    play(1'b0);
    chk("s5_ext_pulses", npulse, 1);
    chk("s5_ext_is_max", is_max, 1);
    chk("s5_ext_value",  val, 1023);

    // Reset in the middle of a refractory window
    mode = 2'd2; thr = '0; len = CW'(20);
    do_reset();
    seq = '{0, 20, -5};
    play(1'b0);
    chk("s6_refr_before", refr, 1);
    rst = 1'b1;
    cyc();
    chk("s6_rst_refr",  refr, 0);
    chk("s6_rst_value", val, 0);
    rst = 1'b0; clr();
    seq = '{5};
    play(1'b0);
    chk("s6_post_pulses", npulse, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(299, 0) == 0);
      ce  = ($urandom_range(1, 0) == 1);
      win = ($urandom_range(4, 0) != 0);
      sv  = ($urandom_range(3, 0) != 0);
      if ($urandom_range(9, 0) == 0) sig = DW'($urandom);
      else                           sig = DW'(int'($urandom_range(40, 0)) - 20);
      if ($urandom_range(49, 0) == 0) begin
        mode = 2'($urandom_range(3, 0));
        thr  = DW'($urandom_range(15, 0));
        len  = CW'($urandom_range(6, 0));
      end
      cyc();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
